regfile_io: RTL and testbench
=============================

REGFILE_IO -- requirements
Module: regfile_io

Interface
REQ-001 Parameter N, default 8: data width in bits.
REQ-002 Parameter AW, default 5: register address width; depth is 2**AW.
REQ-003 Parameter IN_W, default 9: input port width; IN_W > N and IN_W <= 2*N.
REQ-004 Parameter OUT_ADDR, default 29: register mirrored to data_out; 1 <= OUT_ADDR <= 2**AW-3.
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port w, input, 1: write enable.
REQ-008 Port Waddr, input, AW: write destination address.
REQ-009 Port Wdata, input, N: write data.
REQ-010 Port Raddr1 / Raddr2, input, AW each: read addresses.
REQ-011 Port Rdata1 / Rdata2, output, N each: combinational read data.
REQ-012 Port data_in, input, IN_W: asynchronous external switch bus.
REQ-013 Port data_out, output, N: registered copy of register OUT_ADDR.
REQ-014 Port out_strobe, output, 1: one-cycle pulse marking a data_out update.
REQ-015 Port in_event, output, 1: one-cycle pulse when the synchronised input changes.

Function
REQ-016 Address map: 0 is the zero register; 1..2**AW-3 are storage; 2**AW-2 is IN_HI; 2**AW-1 is IN_LO.
REQ-017 Storage is 2**AW-3 registers of N bits, written at the rising edge when w=1 and Waddr is a storage address.
REQ-018 Writes to 0, IN_HI or IN_LO are discarded and change no state.
REQ-019 A read of address 0 returns all zeros.
REQ-020 A read of IN_LO returns sync_in[N-1:0].
REQ-021 A read of IN_HI returns sync_in[IN_W-1:N], zero-extended to N bits.
REQ-022 A read of a storage address returns the stored value, subject to REQ-023.
REQ-023 Write-first forwarding: when w=1, Waddr equals a read address and Waddr is a storage address, that read port returns Wdata in the same cycle.
REQ-024 Both read ports are independent and may address the same location; each is evaluated separately under REQ-019 to REQ-023.
REQ-025 data_in passes through a 2-flop synchroniser (s1, then sync_in), so a change on data_in is first visible on IN_LO/IN_HI 2 rising edges later.
REQ-026 A third register prev_in holds the previous sync_in value.
REQ-027 in_event = 1 for exactly one cycle whenever sync_in != prev_in; it is combinational from these two registers.
REQ-028 data_out is updated from the storage register OUT_ADDR one cycle after that register is written: a write at edge k makes the new value visible on data_out after edge k+1.
REQ-029 out_strobe = 1 during the cycle after edge k+1 only, including when the written value equals the old value.
REQ-030 Back-to-back writes to OUT_ADDR produce one data_out update and one out_strobe per write, with out_strobe held high across consecutive cycles.
REQ-031 Writes to other addresses do not change data_out or out_strobe.

Reset
REQ-032 While reset=1 at a rising edge, every storage register, s1, sync_in, prev_in, data_out and out_strobe is cleared to 0.
REQ-033 Reset has priority over w; a write presented in a reset cycle is discarded.
REQ-034 After reset, Rdata1 and Rdata2 read 0 for every storage address and for IN_LO/IN_HI until the synchroniser fills; in_event = 0.
REQ-035 Reset asserted mid-operation aborts any pending out_strobe; no strobe is issued for a write in the cycle before reset.

Verification
REQ-036 Reset, then w=1, Waddr=5, Wdata=0xA5, Raddr1=5 in the same cycle -> Rdata1=0xA5 (forwarded); next cycle with w=0 -> Rdata1=0xA5 (stored).
REQ-037 Write 0xFF to address 0, then 0x3C to address 31 -> Raddr1=0 reads 0x00 and Raddr2=31 reads the synchronised input, not 0x3C.
REQ-038 data_in=0x1_5A held from edge 0 -> IN_LO reads 0x5A and IN_HI reads 0x01 from edge 2 onward; in_event is high for one cycle only.
REQ-039 Write 0x77 to address 29 at edge k -> data_out=0x77 and out_strobe=1 after edge k+1; out_strobe=0 after edge k+2.
REQ-040 Write to address 29 at edge k and reset=1 at edge k+1 -> data_out=0 and out_strobe=0; address 29 reads 0.
REQ-041 Parameter sweep N=16, AW=4, IN_W=20, OUT_ADDR=13: IN_HI and IN_LO fall at 14 and 15, and REQ-036 to REQ-039 hold with widened values.

Source files
------------

// File: rtl/regfile_io.sv
// Register file with a zero register, two synchronised input words at the top of the
// map, and a registered mirror of one storage register with an update strobe.
module regfile_io #(
  parameter int N        = 8,
  parameter int AW       = 5,
  parameter int IN_W     = 9,
  parameter int OUT_ADDR = 29
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            w,
  input  logic [AW-1:0]   Waddr,
  input  logic [N-1:0]    Wdata,
  input  logic [AW-1:0]   Raddr1,
  input  logic [AW-1:0]   Raddr2,
  output logic [N-1:0]    Rdata1,
  output logic [N-1:0]    Rdata2,
  input  logic [IN_W-1:0] data_in,
  output logic [N-1:0]    data_out,
  output logic            out_strobe,
  output logic            in_event
);

  localparam int DEPTH = 2**AW;
  localparam int NSTOR = DEPTH - 3;
  localparam logic [AW-1:0] A_IN_HI = AW'(DEPTH - 2);
  localparam logic [AW-1:0] A_IN_LO = AW'(DEPTH - 1);
  localparam logic [AW-1:0] A_OUT   = AW'(OUT_ADDR);

  logic [N-1:0]    mem_q [1:NSTOR];
  logic [IN_W-1:0] s1_q, sync_q, prev_q;
  logic [N-1:0]    in_hi;
  logic            pend_q, pend_d;
  logic            strobe_q, strobe_d;
  logic [N-1:0]    data_out_q, data_out_d;

  // Storage is cleared by reset, so it lives in flops rather than block RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i <= NSTOR; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 1; i <= NSTOR; i++) begin
        if (w && (Waddr == AW'(i))) mem_q[i] <= Wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= data_in;
      sync_q <= s1_q;
      prev_q <= sync_q;
    end
  end

  assign in_event = (sync_q != prev_q);

  always_comb begin
    in_hi = '0;
    in_hi[IN_W-N-1:0] = sync_q[IN_W-1:N];
  end

  // pend_q marks that the mirrored register was written on the last edge;
  // the copy and strobe follow one edge later so data_out sees the new value.
  always_comb begin
    pend_d     = w && (Waddr == A_OUT);
    strobe_d   = pend_q;
    data_out_d = pend_q ? mem_q[OUT_ADDR] : data_out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= 1'b0;
      strobe_q   <= 1'b0;
      data_out_q <= '0;
    end else begin
      pend_q     <= pend_d;
      strobe_q   <= strobe_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out   = data_out_q;
  assign out_strobe = strobe_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [AW-1:0] addr;
    logic [N-1:0]  data;

    assign addr = (gi == 0) ? Raddr1 : Raddr2;

    // Special addresses are decoded first, so forwarding only applies to storage.
    always_comb begin
      data = '0;
      if (addr == A_IN_HI) begin
        data = in_hi;
      end else if (addr == A_IN_LO) begin
        data = sync_q[N-1:0];
      end else if (addr != '0) begin
        if (w && (Waddr == addr)) begin
          data = Wdata;
        end else begin
          for (int i = 1; i <= NSTOR; i++) begin
            if (addr == AW'(i)) data = mem_q[i];
          end
        end
      end
    end
  end

  assign Rdata1 = g_rd[0].data;
  assign Rdata2 = g_rd[1].data;

endmodule

// File: tb/tb_regfile_io.sv
// Directed bench for regfile_io: default build plus a widened build (N=16, AW=4).
module tb_regfile_io;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Default parameter instance
  logic       w;
  logic [4:0] waddr, ra1, ra2;
  logic [7:0] wdata, rd1, rd2, dout;
  logic [8:0] din;
  logic       ostb, iev;

  // Widened instance
  logic        bw;
  logic [3:0]  bwaddr, bra1, bra2;
  logic [15:0] bwdata, brd1, brd2, bdout;
  logic [19:0] bdin;
  logic        bostb, biev;

  int total = 0;
  int bad   = 0;

  regfile_io dut_a (
    .clk(clk), .reset(reset), .w(w), .Waddr(waddr), .Wdata(wdata),
    .Raddr1(ra1), .Raddr2(ra2), .Rdata1(rd1), .Rdata2(rd2),
    .data_in(din), .data_out(dout), .out_strobe(ostb), .in_event(iev)
  );

  regfile_io #(.N(16), .AW(4), .IN_W(20), .OUT_ADDR(13)) dut_b (
    .clk(clk), .reset(reset), .w(bw), .Waddr(bwaddr), .Wdata(bwdata),
    .Raddr1(bra1), .Raddr2(bra2), .Rdata1(brd1), .Rdata2(brd2),
    .data_in(bdin), .data_out(bdout), .out_strobe(bostb), .in_event(biev)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1;
    w = 1'b1; waddr = 5'd5; wdata = 8'h11; ra1 = 5'd0; ra2 = 5'd0; din = 9'h000;
    bw = 1'b0; bwaddr = 4'd0; bwdata = 16'h0; bra1 = 4'd0; bra2 = 4'd0; bdin = 20'h0;

    // Reset with a write pending: the write must be discarded
    tick();
    tick();
    reset = 1'b0; w = 1'b0; ra1 = 5'd5; ra2 = 5'd31;
    #1;
    check("rst_rd_5", rd1, 8'h00);
    check("rst_rd_inlo", rd2, 8'h00);
    check("rst_dout", dout, 8'h00);
    check("rst_strobe", ostb, 1'b0);
    check("rst_in_event", iev, 1'b0);

    // Forwarding, then stored value on both ports
    w = 1'b1; waddr = 5'd5; wdata = 8'hA5; ra1 = 5'd5;
    #1;
    check("fwd_5", rd1, 8'hA5);
    tick();
    w = 1'b0; ra2 = 5'd5;
    #1;
    check("stored_5_p1", rd1, 8'hA5);
    check("stored_5_p2", rd2, 8'hA5);

    // Writes to zero register and IN_LO are discarded
    w = 1'b1; waddr = 5'd0; wdata = 8'hFF;
    tick();
    waddr = 5'd31; wdata = 8'h3C; ra2 = 5'd31;
    #1;
    check("no_fwd_inlo", rd2, 8'h00);
    tick();
    w = 1'b0; ra1 = 5'd0; ra2 = 5'd31;
    #1;
    check("zero_reg", rd1, 8'h00);
    check("inlo_not_written", rd2, 8'h00);

    // Synchroniser: data_in visible after the second edge, one-cycle in_event
    din = 9'h15A; ra1 = 5'd31; ra2 = 5'd30;
    tick();
    check("sync_e1_lo", rd1, 8'h00);
    check("sync_e1_event", iev, 1'b0);
    tick();
    check("sync_e2_lo", rd1, 8'h5A);
    check("sync_e2_hi", rd2, 8'h01);
    check("sync_e2_event", iev, 1'b1);
    tick();
    check("sync_e3_lo", rd1, 8'h5A);
    check("sync_e3_event", iev, 1'b0);

    // Mirror update: write at edge k, visible after k+1
    w = 1'b1; waddr = 5'd29; wdata = 8'h77;
    tick();
    w = 1'b0;
    check("mir_k_dout", dout, 8'h00);
    check("mir_k_strobe", ostb, 1'b0);
    tick();
    check("mir_k1_dout", dout, 8'h77);
    check("mir_k1_strobe", ostb, 1'b1);
    tick();
    check("mir_k2_dout", dout, 8'h77);
    check("mir_k2_strobe", ostb, 1'b0);

    // Back-to-back writes, the second repeated with an unchanged value
    w = 1'b1; waddr = 5'd29; wdata = 8'h12;
    tick();
    wdata = 8'h34;
    tick();
    check("b2b_1_dout", dout, 8'h12);
    check("b2b_1_strobe", ostb, 1'b1);
    tick();
    w = 1'b0;
    check("b2b_2_dout", dout, 8'h34);
    check("b2b_2_strobe", ostb, 1'b1);
    tick();
    check("b2b_same_dout", dout, 8'h34);
    check("b2b_same_strobe", ostb, 1'b1);
    tick();
    check("b2b_end_strobe", ostb, 1'b0);

    // Writes elsewhere leave the mirror alone
    w = 1'b1; waddr = 5'd7; wdata = 8'h55;
    tick();
    w = 1'b0;
    tick();
    check("other_dout", dout, 8'h34);
    check("other_strobe", ostb, 1'b0);

    // Reset right after a mirrored write aborts the strobe
    w = 1'b1; waddr = 5'd29; wdata = 8'h99;
    tick();
    w = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; ra1 = 5'd29; ra2 = 5'd31;
    #1;
    check("abort_dout", dout, 8'h00);
    check("abort_strobe", ostb, 1'b0);
    check("abort_rd_29", rd1, 8'h00);
    check("abort_inlo", rd2, 8'h00);
    check("abort_event", iev, 1'b0);

    // Widened build: IN_HI=14, IN_LO=15, OUT_ADDR=13
    bdin = 20'hABCDE; bw = 1'b1; bwaddr = 4'd5; bwdata = 16'hBEEF; bra1 = 4'd5; bra2 = 4'd15;
    #1;
    check("b_fwd_5", brd1, 16'hBEEF);
    tick();
    bw = 1'b0;
    #1;
    check("b_stored_5", brd1, 16'hBEEF);
    check("b_e1_lo", brd2, 16'h0000);
    tick();
    bra1 = 4'd15; bra2 = 4'd14;
    #1;
    check("b_inlo", brd1, 16'hBCDE);
    check("b_inhi", brd2, 16'h000A);
    check("b_event", biev, 1'b1);
    bw = 1'b1; bwaddr = 4'd14; bwdata = 16'h1234;
    #1;
    check("b_inhi_no_fwd", brd2, 16'h000A);
    tick();
    bwaddr = 4'd13; bwdata = 16'hCAFE;
    check("b_inhi_kept", brd2, 16'h000A);
    check("b_event_off", biev, 1'b0);
    tick();
    bw = 1'b0;
    check("b_mir_k_strobe", bostb, 1'b0);
    tick();
    check("b_mir_k1_dout", bdout, 16'hCAFE);
    check("b_mir_k1_strobe", bostb, 1'b1);
    tick();
    check("b_mir_k2_strobe", bostb, 1'b0);
    bra1 = 4'd0;
    #1;
    check("b_zero_reg", brd1, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
